// File: rtl/keys_in_pio.sv
// Avalon-MM input PIO for active-low keys: sync, debounce, falling-edge capture, masked level irq.
// Define KEYS_IN_DEBOUNCE_EN to enable the per-bit debounce counters.
module keys_in_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_stable_next;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

`ifdef KEYS_IN_DEBOUNCE_EN
  logic [CNT_W-1:0] r_cnt      [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];

  // Accept sync2 only after it has differed from stable for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    w_stable_next = r_stable;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          w_stable_next[i] = r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign w_unused = &{1'b0, writedata};
`else
  assign w_stable_next = r_sync2;
  assign w_unused      = &{1'b0, writedata, 32'(DEBOUNCE_CYCLES), 32'(CNT_W)};
`endif

  assign w_wr   = chipselect && !write_n;
  assign w_fall = r_stable & ~w_stable_next;
  assign w_clr  = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Synchronizer, debounced value, mask and edge-capture registers; set wins over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_stable  <= '1;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_sync1   <= in_port;
      r_sync2   <= r_sync1;
      r_stable  <= w_stable_next;
      r_edgecap <= (r_edgecap & ~w_clr) | w_fall;
      if (w_wr && address == ADDR_IRQMASK) r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:    readdata = 32'(r_stable);
        ADDR_IRQMASK: readdata = 32'(r_irqmask);
        ADDR_EDGECAP: readdata = 32'(r_edgecap);
        default:      readdata = '0;
      endcase
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_keys_in_pio.sv
// Directed self-checking bench for keys_in_pio (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_keys_in_pio;

  localparam int unsigned W = 4;
`ifdef KEYS_IN_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] in_port = 4'hF;
  logic         irq;

  int checks = 0;
  int failures = 0;

  keys_in_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // Reset with idle pins
    tick(3);
    reset = 1'b0;
    tick(1);
    rd("rst_data", 2'd0, 32'hF);
    rd("rst_edgecap", 2'd3, 32'h0);
    rd("rst_irqmask", 2'd2, 32'h0);
    rd("rst_reserved", 2'd1, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    address = 2'd0;
    #1;
    check("unselected_rd", readdata, 32'h0);

    // Mask write: upper writedata bits ignored
    wr(2'd2, 32'h0000_0011);
    rd("irqmask_wr", 2'd2, 32'h1);
    check("irq_no_edge", 32'(irq), 32'h0);

    // Clean press on bit 0
    in_port = 4'hE;
    tick(LAT + 1);
    rd("press_data_early", 2'd0, 32'hF);
    rd("press_cap_early", 2'd3, 32'h0);
    check("press_irq_early", 32'(irq), 32'h0);
    tick(1);
    rd("press_data", 2'd0, 32'hE);
    rd("press_cap", 2'd3, 32'h1);
    check("press_irq", 32'(irq), 32'h1);

    wr(2'd2, 32'h0);
    check("mask_off_irq", 32'(irq), 32'h0);

`ifdef KEYS_IN_DEBOUNCE_EN
    // Bit 1 bounces: never holds 4 cycles
    in_port = 4'hC; tick(3);
    in_port = 4'hE; tick(1);
    in_port = 4'hC; tick(3);
    in_port = 4'hE; tick(6);
    rd("bounce_data", 2'd0, 32'hE);
    rd("bounce_cap", 2'd3, 32'h1);
`endif
    // Bit 1 held low
    in_port = 4'hC;
    tick(LAT + 1);
    rd("hold_cap_early", 2'd3, 32'h1);
    tick(1);
    rd("hold_data", 2'd0, 32'hC);
    rd("hold_cap", 2'd3, 32'h3);
    check("hold_irq_masked", 32'(irq), 32'h0);

    // Write-1-clear of bit 0
    wr(2'd3, 32'h1);
    rd("w1c_cap", 2'd3, 32'h2);

    // Clear bits 1 and 2 on the edge bit 2 captures: bit 2 survives
    in_port = 4'h8;
    tick(LAT + 1);
    wr(2'd3, 32'h6);
    rd("set_prio_cap", 2'd3, 32'h4);
    rd("set_prio_data", 2'd0, 32'h8);

    // Mask takes effect after the write edge, clear drops irq
    wr(2'd2, 32'h4);
    check("mask_irq", 32'(irq), 32'h1);

    // Release of bit 0 does not capture
    in_port = 4'h9;
    tick(LAT + 2);
    rd("release_data", 2'd0, 32'h9);
    rd("release_cap", 2'd3, 32'h4);

    wr(2'd3, 32'h4);
    check("clr_irq", 32'(irq), 32'h0);
    rd("clr_cap", 2'd3, 32'h0);

    // Reset two cycles into a press on bit 0
    in_port = 4'h8;
    tick(2);
    reset   = 1'b1;
    in_port = 4'hF;
    tick(3);
    reset = 1'b0;
    tick(LAT + 3);
    rd("midrst_data", 2'd0, 32'hF);
    rd("midrst_cap", 2'd3, 32'h0);
    rd("midrst_mask", 2'd2, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);

`ifndef KEYS_IN_DEBOUNCE_EN
    // Without debounce a single-cycle glitch on bit 3 is captured at edge 2
    in_port = 4'h7;
    tick(1);
    in_port = 4'hF;
    tick(1);
    rd("glitch_cap_early", 2'd3, 32'h0);
    tick(1);
    rd("glitch_cap", 2'd3, 32'h8);
    rd("glitch_data", 2'd0, 32'h7);
    tick(1);
    rd("glitch_data_back", 2'd0, 32'hF);
    rd("glitch_cap_kept", 2'd3, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keys_in_pio.md
# keys_in_pio

Avalon-MM slave input port for active-low push-buttons and switches; the read-side counterpart of the seven-segment output PIOs. Synchronizes and debounces each input bit, latches press (falling) edges into an edge-capture register, and raises a level interrupt for unmasked captured edges. Sits on the system interconnect next to the output PIOs, with `in_port` wired directly to board pins.

## Interface
- `WIDTH`, 4: number of input bits (1..32).
- `DEBOUNCE_CYCLES`, 50000: cycles an input must hold a new value before it is accepted (>= 1).
- `CNT_W`, 16: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; combinational, zero wait states.
- `in_port`  in  WIDTH  asynchronous raw pins; active-low, idle high.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map:
  - addr 0: DATA, read-only; debounced `stable` value.
  - addr 1: reserved; reads 0, writes ignored.
  - addr 2: IRQMASK, read/write; bits [WIDTH-1:0].
  - addr 3: EDGECAP; read returns captured edges; writing 1 to a bit clears it, writing 0 leaves it unchanged.
- `readdata` = selected register zero-extended to 32 bits, 0 when `chipselect`=0. Reads have no side effects.
- A write occurs when `chipselect`=1 and `write_n`=0; `writedata` bits >= WIDTH are ignored.
- Synchronizer: two flops per bit (`sync1`, `sync2`).
- Debounce, per bit independently, with counter `cnt`:
  - if `sync2`==`stable`: `cnt` <= 0.
  - else if `cnt`==DEBOUNCE_CYCLES-1: `stable` <= `sync2`, `cnt` <= 0.
  - else: `cnt` <= `cnt`+1.
  - Any bounce back to `stable` before acceptance restarts the count.
- Edge capture: a bit of EDGECAP sets on the same edge its `stable` bit goes 1->0. Release (0->1) never sets it.
- Set has priority over a write-1-clear on the same cycle; the bit stays 1.
- `irq` = |(EDGECAP & IRQMASK), combinational from registers.
- Reset values:
  - `sync1`, `sync2`, `stable`: all ones.
  - `cnt`, IRQMASK, EDGECAP: 0.
  - Hence `irq`=0 and `readdata`=0 when not selected.
  - Reset held low-pin inputs do not produce an edge until the debounce completes after reset is released.
- Reset asserted mid-debounce discards the pending count; no capture occurs for that transition.

## Timing
- Edge 0 is the first `clk` edge to sample a new `in_port` level.
- `sync2` shows the new level after edge 1.
- `stable` and EDGECAP update at edge DEBOUNCE_CYCLES+1, provided the input holds.
- `irq` asserts in the same cycle as the EDGECAP bit, if unmasked.
- Register writes take effect at the write edge and are readable the next cycle.
- An IRQMASK write changes `irq` in the following cycle.
- An EDGECAP clear drops `irq` after the write edge, unless another unmasked bit remains set.
- Reads are zero-latency: `readdata` is valid in the cycle `address` and `chipselect` are presented.

## Configuration
- `KEYS_IN_DEBOUNCE_EN` defined: debounce counters are present as described above.
- Undefined:
  - No counters; `stable` <= `sync2` every cycle.
  - `stable` and EDGECAP update at edge 2, identical to the defined case with DEBOUNCE_CYCLES=1.
  - `DEBOUNCE_CYCLES` and `CNT_W` are ignored.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, macro defined unless noted.
- Reset then idle `in_port`=4'hF -> DATA reads 0xF, EDGECAP reads 0, IRQMASK reads 0, `irq`=0.
- Clean press: IRQMASK=0x1, `in_port`[0] 1->0 sampled at edge 0 -> DATA bit 0 =0 and EDGECAP=0x1 at edge 5; `irq`=1 that cycle.
- Bounce: bit 1 low 3 cycles, high 1 cycle, low 3 cycles -> no DATA change and no capture; holding low 4+ cycles -> EDGECAP=0x2. With IRQMASK=0, `irq` stays 0.
- Write-1-clear: EDGECAP=0x3, write 0x1 to addr 3 -> EDGECAP reads 0x2 next cycle. Clear of bit 2 on the same edge bit 2 captures -> reads 0x4.
- Release and reset: bit 0 0->1 -> DATA updates, EDGECAP unchanged. `reset` asserted 2 cycles into a press -> no capture, all registers at reset values.
- Macro undefined: `in_port`[3] 1->0 at edge 0 -> EDGECAP=0x8 at edge 2; a 1-cycle glitch is captured.
